instr_mem_encoder: RTL and testbench
====================================

# instr_mem_encoder

Sequential instruction encoder and program loader for the single-cycle MIPS core. It accepts field-level instruction descriptions over a valid/ready stream and packs each into a 32-bit MIPS word using the opcode/funct map the control path decodes (lw, sw, R-type, addi, beq, j). It then writes the words to consecutive instruction-memory addresses through an acknowledged write port. It sits between the testbench or boot source and the instruction memory, ahead of the fetch path.

## Interface
- ADDR_W, 8, word-address width of the instruction-memory write port
- BASE_ADDR, 0, first word address written after each start
- MAX_WORDS, 256, capacity limit in words; BASE_ADDR+MAX_WORDS-1 wraps modulo 2^ADDR_W
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a new load session (honoured in IDLE/DONE only)
- in_valid  in  1  descriptor valid
- in_ready  out  1  encoder can accept a descriptor
- in_kind  in  3  0 lw, 1 sw, 2 R-type, 3 addi, 4 beq, 5 j, 6-7 invalid
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_funct  in  6  R-type funct
- in_imm  in  16  I-type immediate
- in_target  in  26  J-type target
- in_last  in  1  descriptor is final of the session
- im_we  out  1  instruction-memory write request
- im_addr  out  ADDR_W  write word address
- im_wdata  out  32  encoded instruction
- im_ack  in  1  memory accepted the write this cycle
- done  out  1  session finished
- err  out  1  sticky: invalid kind seen or capacity overflow
- word_count  out  ADDR_W+1  words written this session

## Operation
- States: IDLE, ACCEPT, WRITE, DONE. Reset: state IDLE; in_ready, im_we, done, err = 0; im_addr = BASE_ADDR; im_wdata = 0; word_count = 0.
- IDLE/DONE + start: im_addr←BASE_ADDR, word_count←0, err←0, done←0, go ACCEPT.
- ACCEPT: in_ready=1. On in_valid&in_ready, encode and register:
  - lw {100011,rs,rt,imm}; sw {101011,rs,rt,imm}; addi {001000,rs,rt,imm}; beq {000100,rs,rt,imm}
  - R-type {000000,rs,rt,rd,shamt,funct}; j {000010,target}
  - Valid kind: im_wdata←word, latch in_last, go WRITE.
  - Invalid kind: err←1, nothing written. If in_last, go DONE; otherwise stay in ACCEPT.
- WRITE: im_we=1, im_addr/im_wdata held stable, in_ready=0, until im_ack is sampled high. On ack: im_addr←im_addr+1 (wraps), word_count+1. Next state:
  - DONE if latched last.
  - Else DONE with err←1 if the new count equals MAX_WORDS (overflow).
  - Else ACCEPT.
- DONE: done=1 held, in_ready=0, until start.
- start ignored in ACCEPT/WRITE. im_ack ignored when im_we=0.
- Reset mid-session: rst_n low at an edge aborts a pending write (im_we=0 next cycle) and returns all registers to their reset values.

## Timing
- All outputs registered; in_ready, im_we, done are decoded from the registered state (Moore).
- Descriptor accepted at edge N: im_we=1 and im_wdata valid during cycle N+1.
- ack sampled at edge M: im_we=0 and address incremented after M; in_ready=1 in cycle M+1 unless going DONE.
- Peak throughput is one word per 2 cycles with zero-wait memory.
- Overflow check uses the post-increment count, compared at ADDR_W+1 bits so MAX_WORDS=2^ADDR_W is representable.
- done rises the cycle after the final ack (or after an invalid last descriptor is accepted).

## Test plan
- Reset, start, then lw rs=2 rt=3 imm=4 (last), ack immediately -> im_addr 0x00, im_wdata 0x8C430004 for one cycle; done=1, word_count=1, err=0.
- Stream of R-type (rs1 rt2 rd3 funct 0x20), addi (rt8 imm5), beq (rs1 rt2 imm 0xFFFF), sw (rs29 rt31 imm8), and j (target 0x10, last) -> words 0x00221820, 0x20080005, 0x1022FFFF, 0xAFBF0008, 0x08000010 at addresses 0-4; word_count=5.
- im_ack held low 3 cycles on the second word -> im_we, addr, and data stable for 4 cycles; in_ready=0 throughout; no word lost or duplicated.
- Invalid kind 6 mid-stream -> err=1, no write, address unchanged; the next valid descriptor is written at the unchanged address.
- MAX_WORDS=4, BASE_ADDR=254, 6 descriptors without last -> addresses 254, 255, 0, 1 written; DONE with err=1, word_count=4.
- rst_n low while in WRITE with ack withheld -> next cycle im_we=0, state IDLE, word_count=0; a subsequent start restarts at BASE_ADDR.

Source files
------------

// File: rtl/instr_mem_encoder.sv
// instr_mem_encoder
// Packs field-level MIPS instruction descriptors into 32-bit words and writes
// them to consecutive instruction-memory word addresses.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a load session (honoured in IDLE/DONE only)
//   in_valid/in_ready descriptor stream handshake
//   in_kind..in_last  descriptor fields (kind 0 lw, 1 sw, 2 R, 3 addi, 4 beq, 5 j)
//   im_we/im_addr/im_wdata/im_ack  acknowledged instruction-memory write port
//   done              session finished (held until next start)
//   err               sticky: invalid kind or capacity overflow
//   word_count        words written this session
//   fsm_state         current FSM state (debug visibility)
//
// Handshake: a descriptor transfers on a rising edge where in_valid and
// in_ready are both high; a memory write completes on a rising edge where
// im_we and im_ack are both high. im_addr/im_wdata stay stable while im_we
// is high, and im_ack is ignored while im_we is low.
module instr_mem_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              im_ack,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  // One bit wider than the address so a full 2^ADDR_W capacity is representable.
  localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

  logic [1:0]      state;
  logic            last_q;
  logic [31:0]     enc_word;
  logic            enc_ok;
  logic [ADDR_W:0] count_inc;

  // Moore outputs decoded from the registered state.
  assign in_ready  = (state == S_ACCEPT);
  assign im_we     = (state == S_WRITE);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

  assign count_inc = word_count + (ADDR_W + 1)'(1);

  // Opcode/funct map matches what the core's control path decodes.
  always_comb begin
    enc_word = 32'h0;
    enc_ok   = 1'b1;
    case (in_kind)
      3'd0:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
      3'd1:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
      3'd2:    enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      3'd3:    enc_word = {6'b001000, in_rs, in_rt, in_imm};
      3'd4:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
      3'd5:    enc_word = {6'b000010, in_target};
      default: enc_ok   = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_q     <= 1'b0;
      im_addr    <= BASE;
      im_wdata   <= 32'h0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            im_addr    <= BASE;
            word_count <= '0;
            err        <= 1'b0;
            state      <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            if (enc_ok) begin
              im_wdata <= enc_word;
              last_q   <= in_last;
              state    <= S_WRITE;
            end else begin
              // Invalid kinds are dropped; address and count are untouched.
              err <= 1'b1;
              if (in_last) state <= S_DONE;
            end
          end
        end
        S_WRITE: begin
          if (im_ack) begin
            im_addr    <= im_addr + ADDR_W'(1);
            word_count <= count_inc;
            if (last_q) begin
              state <= S_DONE;
            end else if (count_inc == MAX_CNT) begin
              // Capacity reached before the final descriptor arrived.
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_ACCEPT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_encoder.sv
// tb_instr_mem_encoder
// Bench for instr_mem_encoder. Two instances: dut0 with default parameters and
// dut1 with MAX_WORDS=4, BASE_ADDR=254 for the wrap/overflow case. Inputs other
// than start are shared; an idle instance ignores them. sel chooses which
// instance's outputs the driver and responder follow.
module tb_instr_mem_encoder;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic        start0, start1, in_valid, in_last, im_ack;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        rdy0, we0, done0, err0, rdy1, we1, done1, err1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [8:0]  wc0, wc1;
  logic [1:0]  st0, st1;

  instr_mem_encoder dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .in_valid(in_valid), .in_ready(rdy0),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .im_we(we0), .im_addr(addr0), .im_wdata(wdata0), .im_ack(im_ack),
    .done(done0), .err(err0), .word_count(wc0), .fsm_state(st0)
  );

  instr_mem_encoder #(.ADDR_W(8), .BASE_ADDR(254), .MAX_WORDS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid), .in_ready(rdy1),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .im_we(we1), .im_addr(addr1), .im_wdata(wdata1), .im_ack(im_ack),
    .done(done1), .err(err1), .word_count(wc1), .fsm_state(st1)
  );

  logic        sel;
  logic        cur_ready, cur_we, cur_done, cur_err;
  logic [7:0]  cur_addr;
  logic [31:0] cur_wdata;
  logic [8:0]  cur_wc;
  logic [1:0]  cur_st;
  assign cur_ready = sel ? rdy1   : rdy0;
  assign cur_we    = sel ? we1    : we0;
  assign cur_done  = sel ? done1  : done0;
  assign cur_err   = sel ? err1   : err0;
  assign cur_addr  = sel ? addr1  : addr0;
  assign cur_wdata = sel ? wdata1 : wdata0;
  assign cur_wc    = sel ? wc1    : wc0;
  assign cur_st    = sel ? st1    : st0;

  // ---------------- scoreboard ----------------
  logic [39:0] exp_q[$];   // {address, word} in expected write order
  int          wait_q[$];  // ack wait cycles to apply to each expected write
  int          we_hist[$]; // im_we cycles observed per completed write
  logic [7:0]  exp_addr;
  int          checks;
  int          errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int          wait_cnt;
  logic [39:0] held;
  initial begin
    im_ack   = 1'b0;
    wait_cnt = 0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (im_ack) begin
        im_ack   = 1'b0;
        wait_cnt = 0;
      end else if (cur_we) begin
        if (wait_cnt == 0) held = {cur_addr, cur_wdata};
        else check("write_hold", {24'h0, cur_addr, cur_wdata}, {24'h0, held});
        check("ready_in_write", cur_ready, 1'b0);
        if (exp_q.size() == 0) begin
          check("spurious_write", 1'b1, 1'b0);
          im_ack = 1'b1;
        end else if (wait_cnt >= wait_q[0]) begin
          check("write", {24'h0, cur_addr, cur_wdata}, {24'h0, exp_q.pop_front()});
          void'(wait_q.pop_front());
          we_hist.push_back(wait_cnt + 1);
          im_ack = 1'b1;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic s);
    sel      = s;
    exp_addr = s ? 8'd254 : 8'd0;
    we_hist.delete();
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Presents one descriptor and returns at the negedge after it is accepted.
  task automatic send(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                      input logic [15:0] imm, input logic [25:0] target, input logic last,
                      input logic [31:0] word, input int wt);
    int n;
    in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = shamt;
    in_funct = funct; in_imm = imm; in_target = target; in_last = last;
    if (kind < 3'd6) begin
      exp_q.push_back({exp_addr, word});
      wait_q.push_back(wt);
      exp_addr = exp_addr + 8'd1;
    end
    in_valid = 1'b1;
    n = 0;
    while (!cur_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!cur_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", cur_done, 1'b1);
    check("sb_empty", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [4:0]  r_rs, r_rt;
    logic [15:0] r_imm;
    checks = 0; errors = 0;
    sel = 1'b0; rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    in_valid = 1'b0; in_kind = 3'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
    in_shamt = 5'd0; in_funct = 6'd0; in_imm = 16'd0; in_target = 26'd0; in_last = 1'b0;
    exp_addr = 8'd0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_ready", rdy0, 1'b0);
    check("rst_we", we0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_err", err0, 1'b0);
    check("rst_addr", addr0, 8'h00);
    check("rst_wdata", wdata0, 32'h0);
    check("rst_wc", wc0, 9'd0);
    check("rst_state", st0, 2'd0);
    check("rst_addr1", addr1, 8'd254);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_ready", rdy0, 1'b0);

    // single lw, last, immediate ack
    do_start(1'b0);
    check("accept_ready", cur_ready, 1'b1);
    send(3'd0, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 1'b1, 32'h8C430004, 0);
    wait_done();
    check("lw_we_cycles", we_hist[0], 1);
    check("lw_wc", cur_wc, 9'd1);
    check("lw_err", cur_err, 1'b0);
    check("done_no_ready", cur_ready, 1'b0);

    // mixed stream, ack withheld 3 cycles on the second word
    do_start(1'b0);
    check("restart_done_low", cur_done, 1'b0);
    check("restart_wc", cur_wc, 9'd0);
    send(3'd2, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0, 32'h00221820, 0);
    send(3'd3, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0, 32'h20080005, 3);
    send(3'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0, 32'h1022FFFF, 0);
    send(3'd1, 5'd29, 5'd31, 5'd0, 5'd0, 6'd0, 16'd8, 26'd0, 1'b0, 32'hAFBF0008, 0);
    send(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1, 32'h08000010, 0);
    wait_done();
    check("stream_wc", cur_wc, 9'd5);
    check("stream_err", cur_err, 1'b0);
    check("stall_we_cycles", we_hist[1], 4);
    check("stream_addr_after", cur_addr, 8'd5);

    // invalid kind mid-stream: no write, address unchanged, err sticky
    do_start(1'b0);
    send(3'd3, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0, 32'h20851234, 0);
    send(3'd6, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1, 1'b0, 32'h0, 0);
    check("inv_err", cur_err, 1'b1);
    check("inv_we", cur_we, 1'b0);
    check("inv_ready", cur_ready, 1'b1);
    check("inv_addr", cur_addr, 8'd1);
    check("inv_wc", cur_wc, 9'd1);
    send(3'd1, 5'd6, 5'd7, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b1, 32'hACC70010, 0);
    wait_done();
    check("inv_wc_end", cur_wc, 9'd2);
    check("inv_err_sticky", cur_err, 1'b1);

    // invalid last descriptor ends the session without writing
    do_start(1'b0);
    check("start_clears_err", cur_err, 1'b0);
    send(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1, 32'h0, 0);
    wait_done();
    check("inv_last_wc", cur_wc, 9'd0);
    check("inv_last_err", cur_err, 1'b1);

    // random addi stream with random ack latency
    do_start(1'b0);
    for (int i = 0; i < 8; i++) begin
      r_rs  = 5'($urandom_range(0, 31));
      r_rt  = 5'($urandom_range(0, 31));
      r_imm = 16'($urandom_range(0, 65535));
      send(3'd3, r_rs, r_rt, 5'd0, 5'd0, 6'd0, r_imm, 26'd0, (i == 7),
           {6'b001000, r_rs, r_rt, r_imm}, $urandom_range(0, 2));
    end
    wait_done();
    check("rand_wc", cur_wc, 9'd8);

    // capacity overflow with address wrap (dut1: base 254, capacity 4)
    do_start(1'b1);
    check("ovf_start_addr", cur_addr, 8'd254);
    for (int i = 0; i < 4; i++) begin
      r_rt  = 5'($urandom_range(0, 31));
      r_imm = 16'($urandom_range(0, 65535));
      send(3'd0, 5'd1, r_rt, 5'd0, 5'd0, 6'd0, r_imm, 26'd0, 1'b0,
           {6'b100011, 5'd1, r_rt, r_imm}, $urandom_range(0, 1));
    end
    wait_done();
    check("ovf_err", cur_err, 1'b1);
    check("ovf_wc", cur_wc, 9'd4);
    check("ovf_addr_after", cur_addr, 8'd2);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("ovf_no_accept", cur_ready, 1'b0);
    in_valid = 1'b0;

    // reset while a write is stalled
    do_start(1'b0);
    send(3'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0, 32'h8C220001, 0);
    send(3'd2, 5'd3, 5'd4, 5'd5, 5'd2, 6'h00, 16'd0, 26'd0, 1'b0, 32'h00642880, 1000);
    repeat (2) @(negedge clk);
    check("pre_rst_we", cur_we, 1'b1);
    check("pre_rst_wc", cur_wc, 9'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_we", cur_we, 1'b0);
    check("abort_state", cur_st, 2'd0);
    check("abort_wc", cur_wc, 9'd0);
    check("abort_addr", cur_addr, 8'd0);
    exp_q.delete();
    wait_q.delete();
    do_start(1'b0);
    send(3'd0, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 1'b1, 32'h8C430004, 0);
    wait_done();
    check("post_rst_wc", cur_wc, 9'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
